morse_symbol_decoder: RTL and testbench
=======================================

// Module: morse_symbol_decoder
// PURPOSE
//  Downstream receiver for the Morse transmitter's serial LED output (on/off level).
//  Times each mark and space and classifies marks as dot or dash.
//  Assembles up to 4 elements per letter and maps the result to a letter index A..Z (0..25).
//  Result goes to the HEX/LED display path; also a loop-back check of the transmitter.
// PARAMETERS
//  UNIT_CYCLES  25_000_000  clocks per Morse unit (0.5 s at 50 MHz); sim uses 10
//  CNT_W        27          width of duration counter; must hold 4*UNIT_CYCLES
// PORTS
//  CLOCK_50   in   1  system clock; all state on rising edge
//  resetn     in   1  asynchronous, active-low reset
//  morse_in   in   1  raw Morse level from transmitter (1 = mark), asynchronous
//  valid      out  1  one-cycle pulse: letter/pattern/length/error updated
//  letter     out  5  decoded index A=0..Z=25; 31 on error
//  pattern    out  4  element i in bit i (bit0 = first element); 1 = dash; unused bits 0
//  length     out  3  element count 1..4
//  error      out  1  overflow (>4 elements) or pattern not a letter
//  busy       out  1  high while state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, count=0, shift/len/ovf cleared.
//   valid=0, letter=0, pattern=0, length=0, error=0, busy=0.
//  morse_in passes a 2-flop synchronizer; "s_in" is its output (2-cycle delay).
//  Thresholds:
//   MIN_MARK = UNIT_CYCLES/2
//   DASH_MIN = 2*UNIT_CYCLES
//   GAP      = 3*UNIT_CYCLES
//  count increments every cycle in MARK/SPACE and saturates at 4*UNIT_CYCLES.
//  FSM:
//   IDLE:  s_in rise -> MARK, count=0.
//   MARK:  on s_in fall:
//    - count < MIN_MARK: glitch; discarded. Go IDLE if len==0, else SPACE; count=0.
//    - else element = (count >= DASH_MIN). If len<4, shift[len] <= element, len++;
//      else ovf=1. Go SPACE, count=0.
//   SPACE: s_in rise -> MARK, count=0 (inter-element gap; no letter break).
//    - count reaches GAP-1 while s_in low: emit, clear shift/len/ovf, go IDLE.
//  Emit (registered, same cycle as IDLE entry):
//   valid=1 for exactly one cycle; pattern=shift; length=len.
//   ovf or no table match: error=1, letter=31. Else error=0, letter=table(pattern,length).
//  Letter latency: valid exactly GAP cycles after the synchronized falling edge of the last mark.
//  Outputs hold between valid pulses.
//  Table: standard international Morse A..Z, e.g. E=.(1), T=-(1), A=.-, N=-., S=..., O=---,
//   Q=--.-, Y=-.--.
//   Non-letters (..--, .-.-, ---., ----) -> error.
//  Mark lasting past saturation counts as a dash; no timeout while held high.
//  Mark beginning exactly at SPACE count GAP-1: emit wins; the mark starts a new letter from IDLE.
//  resetn low mid-letter: partial letter discarded, no valid pulse.
//  Outputs return to reset values immediately.
// TESTING  (UNIT_CYCLES=10)
//  'A': mark 10, space 10, mark 30, low 40 -> valid once; letter=0, pattern=4'b0010,
//   length=2, error=0; 30 clk after 2nd fall.
//  'S' then 'O' back-to-back, 30-clk letter gap -> two valid pulses; (18, 0000, 3) then (14, 0111, 3).
//  Glitch: 3-clk mark inside 'E' space, then idle -> single valid; letter=4, length=1.
//  Overflow: five 10-clk dots, 10-clk spaces -> valid; error=1, letter=31, length=4, pattern=0000.
//  Invalid '..--' -> error=1, letter=31, pattern=4'b1100, length=4.
//  Reset: resetn low after 2 elements of 'Q' -> no valid pulse; busy=0, all outputs 0.
//   Next clean 'T' decodes to 19.

Source files
------------

// File: rtl/morse_symbol_decoder.sv
// Morse receiver: synchronizes the serial mark/space level, times each element,
// assembles up to four dots/dashes and maps the finished pattern to a letter index A..Z.
module morse_symbol_decoder #(
  parameter int unsigned UNIT_CYCLES = 25_000_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       morse_in,
  output logic       valid,
  output logic [4:0] letter,
  output logic [3:0] pattern,
  output logic [2:0] length,
  output logic       error,
  output logic       busy
);

  localparam logic [CNT_W-1:0] MIN_MARK = CNT_W'(UNIT_CYCLES / 2);
  localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
  // count holds GAP-2 on the edge where it would reach GAP-1, so the emit edge
  // lands exactly GAP cycles after s_in falls
  localparam logic [CNT_W-1:0] GAP_EMIT = CNT_W'(3 * UNIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(4 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [3:0]       shift;
  logic [2:0]       len;
  logic             ovf;
  logic             sync1, s_in;
  logic [5:0]       lut;

  function automatic logic [5:0] decode(input logic [2:0] n, input logic [3:0] p);
    decode = {1'b1, 5'd31};
    case ({n, p})
      7'b001_0000: decode = {1'b0, 5'd4};   // E
      7'b001_0001: decode = {1'b0, 5'd19};  // T
      7'b010_0010: decode = {1'b0, 5'd0};   // A
      7'b010_0000: decode = {1'b0, 5'd8};   // I
      7'b010_0011: decode = {1'b0, 5'd12};  // M
      7'b010_0001: decode = {1'b0, 5'd13};  // N
      7'b011_0000: decode = {1'b0, 5'd18};  // S
      7'b011_0001: decode = {1'b0, 5'd3};   // D
      7'b011_0010: decode = {1'b0, 5'd17};  // R
      7'b011_0011: decode = {1'b0, 5'd6};   // G
      7'b011_0100: decode = {1'b0, 5'd20};  // U
      7'b011_0101: decode = {1'b0, 5'd10};  // K
      7'b011_0110: decode = {1'b0, 5'd22};  // W
      7'b011_0111: decode = {1'b0, 5'd14};  // O
      7'b100_0000: decode = {1'b0, 5'd7};   // H
      7'b100_0001: decode = {1'b0, 5'd1};   // B
      7'b100_0010: decode = {1'b0, 5'd11};  // L
      7'b100_0011: decode = {1'b0, 5'd25};  // Z
      7'b100_0100: decode = {1'b0, 5'd5};   // F
      7'b100_0101: decode = {1'b0, 5'd2};   // C
      7'b100_0110: decode = {1'b0, 5'd15};  // P
      7'b100_1000: decode = {1'b0, 5'd21};  // V
      7'b100_1001: decode = {1'b0, 5'd23};  // X
      7'b100_1011: decode = {1'b0, 5'd16};  // Q
      7'b100_1101: decode = {1'b0, 5'd24};  // Y
      7'b100_1110: decode = {1'b0, 5'd9};   // J
      default:     decode = {1'b1, 5'd31};
    endcase
  endfunction

  always_comb begin
    lut = decode(len, shift);
    if (ovf) lut = {1'b1, 5'd31};
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      s_in  <= 1'b0;
    end else begin
      sync1 <= morse_in;
      s_in  <= sync1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      count   <= '0;
      shift   <= '0;
      len     <= '0;
      ovf     <= 1'b0;
      valid   <= 1'b0;
      letter  <= '0;
      pattern <= '0;
      length  <= '0;
      error   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state != IDLE && count != CNT_SAT) count <= count + CNT_ONE;
      case (state)
        IDLE: begin
          if (s_in) begin
            state <= MARK;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        MARK: begin
          if (!s_in) begin
            count <= '0;
            if (count < MIN_MARK) begin
              if (len == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= SPACE;
              end
            end else begin
              if (len < 3'd4) begin
                shift[len[1:0]] <= (count >= DASH_MIN);
                len             <= len + 3'd1;
              end else begin
                ovf <= 1'b1;
              end
              state <= SPACE;
            end
          end
        end
        SPACE: begin
          // letter break takes priority over a mark starting on the same edge
          if (count == GAP_EMIT) begin
            valid   <= 1'b1;
            pattern <= shift;
            length  <= len;
            error   <= lut[5];
            letter  <= lut[4:0];
            shift   <= '0;
            len     <= '0;
            ovf     <= 1'b0;
            count   <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end else if (s_in) begin
            state <= MARK;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Directed bench for morse_symbol_decoder with UNIT_CYCLES=10: dots 10 clk, dashes 30 clk,
// element spaces 10 clk; every valid pulse is captured for later checks.
module tb_morse_symbol_decoder;

  logic       clk = 1'b0;
  logic       resetn;
  logic       morse_in;
  logic       valid;
  logic [4:0] letter;
  logic [3:0] pattern;
  logic [2:0] length;
  logic       error;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vcount = 0;
  int valid_cyc = 0;
  int fall_cyc = 0;
  int base;
  logic [12:0] caps[$];

  morse_symbol_decoder #(.UNIT_CYCLES(10), .CNT_W(27)) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .morse_in(morse_in),
    .valid   (valid),
    .letter  (letter),
    .pattern (pattern),
    .length  (length),
    .error   (error),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount++;
      valid_cyc = cyc;
      caps.push_back({error, letter, pattern, length});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    morse_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input string code, input int gap);
    for (int unsigned i = 0; i < code.len(); i++) begin
      drive(1'b1, (code[i] == "-") ? 30 : 10);
      if (i + 1 < code.len()) drive(1'b0, 10);
    end
    fall_cyc = cyc;
    drive(1'b0, gap);
  endtask

  initial begin
    resetn   = 1'b0;
    morse_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_letter", letter, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    resetn = 1'b1;
    drive(1'b0, 5);

    // 'A' plus latency from the raw last fall: 2 synchronizer cycles + GAP
    base = vcount;
    send(".-", 40);
    check("A_pulses", vcount - base, 1);
    check("A_letter", letter, 0);
    check("A_pattern", pattern, 4'b0010);
    check("A_length", length, 2);
    check("A_error", error, 0);
    check("A_latency", valid_cyc - fall_cyc, 32);
    check("A_busy_after", busy, 0);

    // 'S' then 'O' separated by exactly a 30-clk letter gap
    base = vcount;
    send("...", 30);
    send("---", 40);
    check("SO_pulses", vcount - base, 2);
    if (caps.size() >= 3) begin
      check("S_letter", caps[1][11:7], 18);
      check("S_pattern", caps[1][6:3], 4'b0000);
      check("S_length", caps[1][2:0], 3);
      check("O_letter", caps[2][11:7], 14);
      check("O_pattern", caps[2][6:3], 4'b0111);
      check("O_length", caps[2][2:0], 3);
    end else begin
      check("SO_captures", caps.size(), 3);
    end

    // 'E' with a 3-clk glitch inside its trailing space
    base = vcount;
    drive(1'b1, 10);
    drive(1'b0, 10);
    drive(1'b1, 3);
    drive(1'b0, 45);
    check("glitch_pulses", vcount - base, 1);
    check("glitch_letter", letter, 4);
    check("glitch_length", length, 1);
    check("glitch_error", error, 0);

    // five dots overflow the 4-element shift register
    base = vcount;
    send(".....", 40);
    check("ovf_pulses", vcount - base, 1);
    check("ovf_error", error, 1);
    check("ovf_letter", letter, 31);
    check("ovf_length", length, 4);
    check("ovf_pattern", pattern, 4'b0000);

    // '..--' is a valid pattern but not a letter
    send("..--", 40);
    check("inv_error", error, 1);
    check("inv_letter", letter, 31);
    check("inv_pattern", pattern, 4'b1100);
    check("inv_length", length, 4);

    // 'Y' decodes with mixed elements
    send("-.--", 40);
    check("Y_letter", letter, 24);
    check("Y_pattern", pattern, 4'b1101);
    check("Y_error", error, 0);

    // reset in the middle of 'Q' after two dashes
    base = vcount;
    drive(1'b1, 30);
    drive(1'b0, 10);
    drive(1'b1, 30);
    drive(1'b0, 5);
    check("preQ_busy", busy, 1);
    resetn = 1'b0;
    #1;
    check("rstQ_busy", busy, 0);
    check("rstQ_letter", letter, 0);
    check("rstQ_pattern", pattern, 0);
    check("rstQ_length", length, 0);
    check("rstQ_error", error, 0);
    drive(1'b0, 3);
    resetn = 1'b1;
    drive(1'b0, 40);
    check("rstQ_no_valid", vcount - base, 0);

    // 'T' with a 50-clk mark that runs the counter into saturation
    base = vcount;
    drive(1'b1, 50);
    drive(1'b0, 40);
    check("T_pulses", vcount - base, 1);
    check("T_letter", letter, 19);
    check("T_pattern", pattern, 4'b0001);
    check("T_length", length, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
